// File: rtl/sram_arb_pkg.sv
// Shared defaults and packed-bus helpers for the multi-client SRAM arbiter.
package sram_arb_pkg;

  localparam int SRAM_ARB_NCH_DEF = 2;
  localparam int SRAM_ARB_AW_DEF  = 4;
  localparam int SRAM_ARB_DW_DEF  = 32;

  // Bit offset of channel ch inside a packed bus whose fields are width bits wide.
  function automatic int ch_off(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// Round-robin arbiter: grants the first requester found cyclically from rr_ptr.
module sram_rr_arb
  import sram_arb_pkg::*;
#(
  parameter int NCH = SRAM_ARB_NCH_DEF,
  parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  gnt_idx,
  output logic           gnt_any
);

  logic [IW-1:0] rr_ptr;
  int            cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int k = 0; k < NCH; k++) begin
      cand = (int'(rr_ptr) + k) % NCH;
      // Reset blocks every grant so nothing is written or read while rst is high.
      if (!gnt_any && !rst && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = IW'(cand);
        gnt_any   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sram_arb_if.sv
// Single-port SRAM shared by NCH req/ack clients through a round-robin arbiter.
// Define SRAM_ARB_BYTE_EN_EN to add per-byte write enables (ch_be).
module sram_arb_if
  import sram_arb_pkg::*;
#(
  parameter int NCH = SRAM_ARB_NCH_DEF,
  parameter int AW  = SRAM_ARB_AW_DEF,
  parameter int DW  = SRAM_ARB_DW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      ch_req,
  input  logic [NCH-1:0]      ch_wen,
  input  logic [NCH*AW-1:0]   ch_addr,
  input  logic [NCH*DW-1:0]   ch_wdata,
`ifdef SRAM_ARB_BYTE_EN_EN
  input  logic [NCH*(DW/8)-1:0] ch_be,
`endif
  output logic [NCH-1:0]      ch_ack,
  output logic [NCH-1:0]      ch_rvalid,
  output logic [NCH*DW-1:0]   ch_rdata,
  output logic                busy
);

  localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DEPTH = 1 << AW;

  logic [IW-1:0]     gnt_idx;
  logic              gnt_any;
  int                sel;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;
  logic              sel_wen;
  logic              do_wr;
  logic              do_rd;
  logic [DW-1:0]     mem [DEPTH];
  logic [NCH*DW-1:0] rdata_q;
  logic [NCH-1:0]    rvalid_q;
  logic              busy_q;

  sram_rr_arb #(
    .NCH (NCH),
    .IW  (IW)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (ch_req),
    .gnt     (ch_ack),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign sel       = int'(gnt_idx);
  assign sel_addr  = ch_addr[ch_off(sel, AW) +: AW];
  assign sel_wdata = ch_wdata[ch_off(sel, DW) +: DW];
  assign sel_wen   = ch_wen[gnt_idx];
  assign do_wr     = gnt_any & sel_wen;
  assign do_rd     = gnt_any & ~sel_wen;

`ifdef SRAM_ARB_BYTE_EN_EN
  localparam int BW = DW / 8;
  logic [BW-1:0] sel_be;
  assign sel_be = ch_be[ch_off(sel, BW) +: BW];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int b = 0; b < BW; b++) begin
        if (sel_be[b]) mem[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (do_wr) mem[sel_addr] <= sel_wdata;
  end
`endif

  // Contents survive reset; only the per-channel read registers are cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      if (do_rd) rdata_q[ch_off(sel, DW) +: DW] <= mem[sel_addr];
      rvalid_q <= do_rd ? ch_ack : '0;
      busy_q   <= |ch_req;
    end
  end

  assign ch_rdata  = rdata_q;
  assign ch_rvalid = rvalid_q;
  assign busy      = busy_q;

endmodule

// File: doc/sram_arb_if.md
Name: sram_arb_if

Overview:
- Parametrised successor to the single-client SRAM interface.
- Holds one single-port synchronous SRAM array shared by NCH independent client channels.
- Clients use a req/ack handshake; a round-robin arbiter grants one access per cycle.
- Intended as the memory-side block that HLS-generated modules (mod_main-style s_addr/s_wen/s_wdata/s_rdata users) attach to when several threads share one memory.

Parameters:
- NCH, 2, number of client channels (1..8)
- AW, 4, address width; depth = 2**AW words
- DW, 32, data width in bits (multiple of 8)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ch_req  in  NCH  per-channel access request, level, held until ack
- ch_wen  in  NCH  per-channel write enable (1=write, 0=read), valid with req
- ch_addr  in  NCH*AW  packed addresses, channel i at [i*AW +: AW]
- ch_wdata  in  NCH*DW  packed write data, channel i at [i*DW +: DW]
- ch_ack  out  NCH  one-hot/zero grant pulse, combinational, same cycle as accept
- ch_rvalid  out  NCH  read data valid, registered, one cycle after read ack
- ch_rdata  out  NCH*DW  packed read data; channel i field holds its last read result
- busy  out  1  registered; high while any ch_req was pending last cycle

Behaviour:
- Reset: all outputs are 0. rr_ptr=0. Memory contents are not cleared.
- Clock and reset: clock clk, reset rst, synchronous, active-high.
- Arbitration (each cycle):
  - Grant the lowest index i, searched cyclically from rr_ptr, with ch_req[i]=1.
  - ch_ack[i]=1 combinationally; at most one ack bit is high per cycle.
  - No request pending: ch_ack=0 and rr_ptr holds.
  - On a grant, at the clock edge rr_ptr <= (i+1) mod NCH.
- Clients must hold addr, wen and wdata stable from req rise until the ack cycle. They may drop req or issue a new request on the cycle after ack.
- Write: when ch_ack[i]&ch_wen[i], mem[addr_i] <= wdata_i at that edge. No rvalid is generated.
- Read:
  - When ch_ack[i]&~ch_wen[i], the granted channel's ch_rdata field is loaded with mem[addr_i] at that edge.
  - ch_rvalid[i] pulses high for exactly the following cycle; this is 1-cycle read latency.
  - Other channels' rdata fields hold their values.
- Read-after-write: a write at cycle t and a read of the same address granted at t+1 returns the new data. A write and a read cannot occur in the same cycle.
- Back-to-back grants to different channels are allowed every cycle, for a sustained throughput of one access per cycle.
- Fairness: with all NCH requests continuously asserted, each channel is granted exactly once per NCH cycles.
- NCH=1: the arbiter degenerates; ack = req.
- Address wrap: the address is used modulo depth; there is no out-of-range detection.
- Reset mid-operation: a pending rvalid is suppressed (rvalid=0 after the reset edge). A write on the reset cycle is discarded, and ack is forced to 0 while rst=1.
- busy <= |ch_req each cycle; it is 0 during reset.

Optional Feature:
- Macro: SRAM_ARB_BYTE_EN_EN.
- With the macro defined:
  - Adds input ch_be of width NCH*(DW/8), packed.
  - A write updates only the bytes whose be bit is 1.
  - be=0 with wen=1 is a legal no-op write that is still acked.
  - Reads ignore be.
- Without the macro: the port is absent and every write is full-word.

Decomposition:
- Shared include/package sram_arb_pkg holds:
  - Default constants SRAM_ARB_NCH_DEF, SRAM_ARB_AW_DEF, SRAM_ARB_DW_DEF.
  - The field-slice helper: channel-offset function for packed buses.
- One sub-module, sram_rr_arb(NCH):
  - Inputs: req, rr_ptr update.
  - Outputs: one-hot grant and the encoded index.
- The memory array and datapath stay in sram_arb_if.

Test Plan:
- Single channel, ch0 write addr 7 data 5, then read addr 7 -> ack on each request cycle; ch_rvalid[0] one cycle after the read ack; rdata0 = 5.
- ch0 and ch1 request together, ch0 write addr 3=0xAA, ch1 read addr 3, from reset -> ch0 acked first (rr_ptr=0), ch1 acked next cycle, rdata1 = 0xAA.
- All NCH=2 channels hold reads of addr 0..1 for 8 cycles -> acks alternate 0,1,0,1; every ack is followed by rvalid on the same channel one cycle later.
- Write addr 15 = 0x12345678, then read addr 31 (AW=4 wrap) -> 0x12345678.
- Read acked, rst asserted on the next edge -> ch_rvalid stays 0, all acks 0 during rst; after release, the first request is granted to ch0.
- SRAM_ARB_BYTE_EN_EN: write 0xFFFFFFFF to addr 2, then write 0x00000000 with be=4'b0101 -> reading addr 2 returns 0xFF00FF00.
